mem_port: RTL



---
 rtl/mem_port.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_port.sv
// Memory bus port: runs one read or write strobe/ready transaction at a time.
// Read data lands in a memory data register. A strobe left waiting for
// TIMEOUT cycles is aborted and raises a sticky err flag.
module mem_port #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Counter only has to reach TIMEOUT-1, so it never wraps.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Next-state and next-output logic; outputs are registered from these.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        rdata_d     = rdata_q;
        err_d       = err_q;

        unique case (state_q)
            StIdle: begin
                // Read wins when both requests are present.
                if (rd_req) begin
                    mem_addr_d = addr;
                    mem_rd_d   = 1'b1;
                    err_d      = 1'b0;
                    cnt_d      = '0;
                    state_d    = StRead;
                end else if (wr_req) begin
                    mem_addr_d  = addr;
                    mem_wdata_d = wdata;
                    mem_wr_d    = 1'b1;
                    err_d       = 1'b0;
                    cnt_d       = '0;
                    state_d     = StWrite;
                end
            end
            StRead: begin
                // Ready is checked first so a late ready beats the timeout.
                if (mem_ready) begin
                    rdata_d  = mem_rdata;
                    mem_rd_d = 1'b0;
                    state_d  = StDone;
                end else if (cnt_q == CNT_LAST) begin
                    mem_rd_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWrite: begin
                if (mem_ready) begin
                    mem_wr_d = 1'b0;
                    state_d  = StDone;
                end else if (cnt_q == CNT_LAST) begin
                    mem_wr_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
